// File: rtl/score_display.sv
// Saturating two-digit BCD score counter driving a multiplexed, active-low 7-segment display.
// Optional: define SCORE_LEADING_ZERO_BLANK_EN to blank the tens digit while it is zero.
module score_display #(
  parameter int unsigned SCAN_DIV = 25000,
  parameter int unsigned MAX_TENS = 9
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       hit,
  input  logic       clear,
  output logic [7:0] score_bcd,
  output logic       sat,
  output logic [6:0] seg,
  output logic [1:0] COM
);

  localparam int unsigned    PW        = $clog2(SCAN_DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [7:0]     SAT_VAL   = {4'(MAX_TENS), 4'd9};
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;

  typedef enum logic {
    SHOW_ONES = 1'b0,
    SHOW_TENS = 1'b1
  } state_t;

  logic [7:0]    score_q, score_d;
  logic          sat_q, sat_d;
  logic [PW-1:0] presc_q, presc_d;
  state_t        state_q, state_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    com_q, com_d;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  // Score path: clear beats hit; per-nibble BCD increment, no binary intermediate.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    score_d = score_q;
    if (clear) begin
      score_d = 8'h00;
    end else if (hit && (score_q != SAT_VAL)) begin
      if (score_q[3:0] == 4'd9) begin
        score_d[3:0] = 4'd0;
        score_d[7:4] = score_q[7:4] + 4'd1;
      end else begin
        score_d[3:0] = score_q[3:0] + 4'd1;
      end
    end
    sat_d = (score_d == SAT_VAL);
  end

  // Scan FSM; seg is decoded from the next-state digit so seg and COM switch together.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q + PW'(1);
    com_d   = 2'b01;
    seg_d   = SEG_BLANK;
    if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      state_d = (state_q == SHOW_ONES) ? SHOW_TENS : SHOW_ONES;
    end
    case (state_d)
      SHOW_ONES: begin
        com_d = 2'b01;
        seg_d = seg_decode(score_q[3:0]);
      end
      SHOW_TENS: begin
        com_d = 2'b10;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        seg_d = (score_q[7:4] == 4'd0) ? SEG_BLANK : seg_decode(score_q[7:4]);
`else
        seg_d = seg_decode(score_q[7:4]);
`endif
      end
      default: begin
        com_d = 2'b01;
        seg_d = SEG_BLANK;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (reset) begin
      score_q <= 8'h00;
      sat_q   <= 1'b0;
      presc_q <= '0;
      state_q <= SHOW_ONES;
      seg_q   <= 7'b0000001;
      com_q   <= 2'b01;
    end else begin
      score_q <= score_d;
      sat_q   <= sat_d;
      presc_q <= presc_d;
      state_q <= state_d;
      seg_q   <= seg_d;
      com_q   <= com_d;
    end
  end

  assign score_bcd = score_q;
  assign sat       = sat_q;
  assign seg       = seg_q;
  assign COM       = com_q;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: a behavioural model pushes expected outputs per driven
// cycle; they are popped and compared after the following rising edge.
module tb_score_display;

  localparam int unsigned SCAN_DIV = 4;

  logic       CLK;
  logic       reset;
  logic       hit;
  logic       clear;
  logic [7:0] score_bcd;
  logic       sat;
  logic [6:0] seg;
  logic [1:0] COM;

  score_display #(.SCAN_DIV(SCAN_DIV), .MAX_TENS(9)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .hit       (hit),
    .clear     (clear),
    .score_bcd (score_bcd),
    .sat       (sat),
    .seg       (seg),
    .COM       (COM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] score;
    logic       sat;
    logic [1:0] com;
    logic [6:0] seg;
  } exp_t;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  int   m_num   = 0;   // score as an integer 0..99
  int   m_presc = 0;
  logic m_sel   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int digit, input logic tens_sel);
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    if (tens_sel && digit == 0) return 7'b1111111;
`endif
    return SEG_TAB[digit];
  endfunction

  // Drive one cycle, push the model's expectation, then compare after the edge.
  task automatic cycle(input logic h, input logic c, input logic r);
    exp_t e;
    exp_t got_e;
    logic sel_n;
    hit   = h;
    clear = c;
    reset = r;
    if (r) begin
      e.seg   = 7'b0000001;
      m_num   = 0;
      m_presc = 0;
      m_sel   = 1'b0;
    end else begin
      sel_n = m_sel;
      if (m_presc == SCAN_DIV - 1) begin
        m_presc = 0;
        sel_n   = ~m_sel;
      end else begin
        m_presc++;
      end
      e.seg = sel_n ? model_seg(m_num / 10, 1'b1) : model_seg(m_num % 10, 1'b0);
      m_sel = sel_n;
      if (c) m_num = 0;
      else if (h && m_num < 99) m_num++;
    end
    e.score = {4'(m_num / 10), 4'(m_num % 10)};
    e.sat   = (m_num == 99);
    e.com   = m_sel ? 2'b10 : 2'b01;
    sb.push_back(e);

    @(posedge CLK);
    @(negedge CLK);
    if (sb.size() == 0) begin
      check("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      got_e = sb.pop_front();
      check("score_bcd", 32'(score_bcd), 32'(got_e.score));
      check("sat",       32'(sat),       32'(got_e.sat));
      check("COM",       32'(COM),       32'(got_e.com));
      check("seg",       32'(seg),       32'(got_e.seg));
      check("nibble_le9", 32'((score_bcd[3:0] <= 4'd9) && (score_bcd[7:4] <= 4'd9)), 32'd1);
    end
  endtask

  initial begin
    hit   = 1'b0;
    clear = 1'b0;
    reset = 1'b1;

    // Reset held three cycles
    repeat (3) cycle(1'b0, 1'b0, 1'b1);

    // Idle scan: COM toggles every SCAN_DIV cycles, tens shows zero (or blank)
    repeat (12) cycle(1'b0, 1'b0, 1'b0);

    // Ten back-to-back hits then watch both digits
    repeat (10) cycle(1'b1, 1'b0, 1'b0);
    check("score_after_10", 32'(score_bcd), 32'h10);
    repeat (9) cycle(1'b0, 1'b0, 1'b0);

    // Saturation: 105 hits from zero, with some spaced-out hits in the mix
    cycle(1'b0, 1'b1, 1'b0);
    repeat (99) cycle(1'b1, 1'b0, 1'b0);
    check("score_at_99", 32'(score_bcd), 32'h99);
    check("sat_at_99",   32'(sat),       32'd1);
    repeat (3) cycle(1'b1, 1'b0, 1'b0);
    repeat (3) begin
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
    end
    check("score_held_99", 32'(score_bcd), 32'h99);

    // Score 37, then clear and hit together
    cycle(1'b0, 1'b1, 1'b0);
    repeat (37) cycle(1'b1, 1'b0, 1'b0);
    check("score_37", 32'(score_bcd), 32'h37);
    cycle(1'b1, 1'b1, 1'b0);
    check("clear_wins", 32'(score_bcd), 32'h00);
    repeat (6) cycle(1'b0, 1'b0, 1'b0);

    // Score 45, then a one-cycle reset mid-dwell and a full dwell afterwards
    repeat (45) cycle(1'b1, 1'b0, 1'b0);
    check("score_45", 32'(score_bcd), 32'h45);
    repeat (2) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);
    check("reset_com", 32'(COM), 32'b01);
    repeat (SCAN_DIV - 1) cycle(1'b0, 1'b0, 1'b0);
    check("no_early_toggle", 32'(COM), 32'b01);
    cycle(1'b0, 1'b0, 1'b0);
    check("toggle_after_div", 32'(COM), 32'b10);
    repeat (5) cycle(1'b1, 1'b0, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Downstream consumer of the brick-breaker game core.
- Counts brick-hit pulses into a saturating two-digit BCD score (00–99).
- Drives the two-digit multiplexed 7-segment display (segments a–g plus the COM digit-select pair).
- Replaces ad-hoc score counting and digit scanning with one registered, testable stage clocked on the system clock.

Parameters:
- SCAN_DIV, 25000: system-clock cycles per digit dwell. Legal range 2..2^20.
- MAX_TENS, 9: highest tens value. The score saturates at {MAX_TENS, 9}.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- hit  input  1  one-cycle pulse per brick destroyed. Each high cycle is one hit.
- clear  input  1  synchronous score clear (new game); does not reset the scan.
- score_bcd  output  8  registered score, {tens[7:4], ones[3:0]}.
- sat  output  1  high while the score equals the saturation value.
- seg  output  7  {a,b,c,d,e,f,g}, active-low, registered.
- COM  output  2  digit select, registered. 2'b01 = ones digit, 2'b10 = tens digit.

Behaviour:
- Clock and reset: one clock, CLK. reset is synchronous and active-high, sampled only on the rising edge of CLK.
- Reset values:
  - score_bcd = 8'h00, sat = 0.
  - Prescaler = 0, digit_sel = 0 (ones).
  - COM = 2'b01, seg = 7'b0000001.
  - reset asserted mid-dwell or mid-count restarts everything from these values on the next edge.
- Score update, in priority order each cycle:
  1. clear: score to 00, sat to 0. Any hit in the same cycle is dropped.
  2. hit with score below saturation:
     - ones < 9: ones + 1.
     - ones == 9: ones to 0, tens + 1.
  3. hit at saturation: no change, sat stays 1.
- Score latency: score_bcd and sat change on the edge after the hit/clear cycle. Back-to-back hit cycles each count.
- sat: registered; equals (score_bcd == {MAX_TENS,4'd9}) after every update.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1, then wraps.
  - On the wrap edge, digit_sel toggles.
  - Each digit is therefore shown for exactly SCAN_DIV cycles.
- Scan FSM, two states:
  - SHOW_ONES (COM=01) to SHOW_TENS (COM=10) on wrap.
  - SHOW_TENS to SHOW_ONES on wrap.
  - No other transitions.
- Segment register:
  - Each cycle, seg is loaded from the decode of the digit selected by the next-state digit_sel, using the current score_bcd.
  - seg and COM therefore always change on the same edge; no ghosting cycle.
  - A score change is visible on seg at most 1 cycle after score_bcd updates, i.e. 2 cycles after the hit, while its digit is selected.
- Decode (a..g, active-low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - Any nibble above 9 (unreachable) = 1111111 (blank).
- Arithmetic: per-nibble 4-bit BCD. No binary intermediate. No nibble may ever hold A–F.

Optional Feature:
- Macro: SCORE_LEADING_ZERO_BLANK_EN.
- Defined: while tens == 0 and SHOW_TENS is active, seg = 7'b1111111 (blank). COM still toggles normally.
- Undefined: tens digit is always decoded, so 0 shows as 0000001.
- score_bcd and sat behave identically either way.

Test Plan:
- Reset held 3 cycles, then released → score_bcd=8'h00, sat=0, COM=2'b01, seg=7'b0000001 on the first post-reset edge.
- SCAN_DIV=4, no hits → COM toggles 01→10→01 every 4 cycles. While COM=10, seg=0000001 (blank 1111111 with SCORE_LEADING_ZERO_BLANK_EN).
- 10 consecutive one-cycle hits → score_bcd steps 01..09 then 8'h10. When the ones digit is selected: seg=0000001 (ones) and, when COM=10, 1001111 (tens).
- 105 hits → score_bcd=8'h99 after hit 99, sat=1, no change for hits 100–105. No nibble ever exceeds 9.
- Score 8'h37: clear and hit asserted in the same cycle → next edge score_bcd=8'h00, sat=0. Prescaler and COM phase undisturbed.
- Score 8'h45 mid-dwell: reset pulse for 1 cycle → all outputs at reset values on the next edge. The next COM toggle occurs exactly SCAN_DIV cycles later.
